feedback_uart_rx: RTL and testbench



---
 rtl/drive_pkg.sv | 27 ++
 rtl/baud_tick_gen.sv | 38 +++
 rtl/feedback_uart_rx.sv | 140 ++++++++++++++
 tb/tb_feedback_uart_rx.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared constants and types for the driving-mode datapath
//
// Shared by the feedback receiver, command transmitter and mode FSMs.
// Feedback byte layout: [7:6] marker, [5:4] reserved, [3:0] obstacle flags.
package drive_pkg;

  localparam logic [1:0] MARKER    = 2'b10;
  localparam logic [7:0] IDLE_BYTE = 8'h80;

  localparam int DET_FRONT = 0;
  localparam int DET_LEFT  = 1;
  localparam int DET_RIGHT = 2;
  localparam int DET_BACK  = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  function automatic logic marker_ok(input logic [7:0] b, input logic [1:0] m);
    return b[7:6] == m;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter with half and full period ticks
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   clr        restart the period (counter to 0 on next edge)
//   half_tick  high in the cycle the counter holds CLKS_PER_BIT/2-1
//   full_tick  high in the cycle the counter holds CLKS_PER_BIT-1
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign half_tick = (cnt_q == HALF);
  assign full_tick = (cnt_q == LAST);

endmodule

// File: rtl/feedback_uart_rx.sv
// rtl/feedback_uart_rx.sv - UART receiver for simulator feedback bytes
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   rec        last accepted feedback byte
//   rec_valid  one-cycle pulse when rec is updated
//   detectors  rec[3:0]: {back, right, left, front}
//   frame_err  one-cycle pulse on bad stop bit or bad marker
//   busy       frame in progress
module feedback_uart_rx
  import drive_pkg::*;
#(
  parameter int         CLK_FREQ     = 100_000_000,
  parameter int         BAUD         = 9600,
  parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter logic [1:0] RX_MARKER    = MARKER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rec,
  output logic       rec_valid,
  output logic [3:0] detectors,
  output logic       frame_err,
  output logic       busy
);

  logic      rx_meta_q, rxs_q;
  rx_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rec_q, rec_d;
  logic [3:0] det_q, det_d;
  logic       rec_valid_q, rec_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       half_tick, full_tick, baud_clr;

  // Any state change restarts the bit period, so every state measures
  // its wait from its own entry cycle.
  assign baud_clr = (state_d != state_q);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clr       (baud_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rec_d       = rec_q;
    det_d       = det_q;
    rec_valid_d = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          state_d   = RX_START;
          bit_cnt_d = '0;
        end
      end
      RX_START: begin
        if (half_tick) state_d = rxs_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (full_tick) begin
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (full_tick) begin
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_IDLE;
          end else if (marker_ok(shift_q, RX_MARKER)) begin
            rec_d            = shift_q;
            det_d[DET_FRONT] = shift_q[DET_FRONT];
            det_d[DET_LEFT]  = shift_q[DET_LEFT];
            det_d[DET_RIGHT] = shift_q[DET_RIGHT];
            det_d[DET_BACK]  = shift_q[DET_BACK];
            rec_valid_d      = 1'b1;
            state_d          = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        // A held-low line (break) must go high before a new start is seen.
        if (rxs_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rec_q       <= IDLE_BYTE;
      det_q       <= '0;
      rec_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rec_q       <= rec_d;
      det_q       <= det_d;
      rec_valid_q <= rec_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rec       = rec_q;
  assign detectors = det_q;
  assign rec_valid = rec_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_feedback_uart_rx.sv
// tb/tb_feedback_uart_rx.sv - directed bench for feedback_uart_rx
module tb_feedback_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rec;
  logic       rec_valid;
  logic [3:0] detectors;
  logic       frame_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int n_valid     = 0;
  int n_ferr      = 0;
  int n_both      = 0;
  logic [7:0] rec_at_pulse = 8'h00;
  int v0, f0;

  feedback_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rec       (rec),
    .rec_valid (rec_valid),
    .detectors (detectors),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec_valid) begin
      n_valid++;
      rec_at_pulse = rec;
    end
    if (frame_err) n_ferr++;
    if (rec_valid && frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                            input int idle_after);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop_v, stop_len);
    drive_bit(1'b1, idle_after);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(4);
    check("reset_rec", 32'(rec), 32'h80);
    check("reset_det", 32'(detectors), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_valid", 32'(rec_valid), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    rst = 1'b0;

    tick(100);
    check("idle_valid_cnt", 32'(n_valid), 32'd0);
    check("idle_ferr_cnt", 32'(n_ferr), 32'd0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_rec", 32'(rec), 32'h80);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h85, 1'b1, CPB, 20);
    check("f85_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("f85_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    check("f85_rec", 32'(rec), 32'h85);
    check("f85_det", 32'(detectors), 32'h5);
    check("f85_rec_at_pulse", 32'(rec_at_pulse), 32'h85);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h45, 1'b1, CPB, 20);
    check("f45_ferr_cnt", 32'(n_ferr - f0), 32'd1);
    check("f45_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("f45_rec_kept", 32'(rec), 32'h85);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA3, 1'b0, 40, 0);
    check("break_busy", 32'(busy), 32'h1);
    drive_bit(1'b1, 20);
    check("break_ferr_cnt", 32'(n_ferr - f0), 32'd1);
    check("break_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("break_busy_after", 32'(busy), 32'h0);
    check("break_rec_kept", 32'(rec), 32'h85);
    v0 = n_valid;
    send_frame(8'h8F, 1'b1, CPB, 20);
    check("f8F_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("f8F_rec", 32'(rec), 32'h8F);
    check("f8F_det", 32'(detectors), 32'hF);

    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check("glitch_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("glitch_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    check("glitch_busy", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b1, CPB, 20);
    check("f81_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("f81_rec", 32'(rec), 32'h81);
    check("f81_det", 32'(detectors), 32'h1);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h9A, 1'b1, CPB, 0);
    send_frame(8'h86, 1'b1, CPB, 20);
    check("b2b_valid_cnt", 32'(n_valid - v0), 32'd2);
    check("b2b_rec", 32'(rec), 32'h86);
    check("b2b_det", 32'(detectors), 32'h6);

    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 8);
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_rec", 32'(rec), 32'h80);
    check("rst_det", 32'(detectors), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick(40);
    check("rst_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("rst_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h82, 1'b1, CPB, 20);
    check("f82_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("f82_rec", 32'(rec), 32'h82);
    check("f82_det", 32'(detectors), 32'h2);

    check("never_both", 32'(n_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
